// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands in a small FIFO, issues them one at a time
// to a combinational ALU and returns each result under a tagged valid/ready handshake.
module alu_cmd_issuer #(
    parameter int Width = 8,
    parameter int Depth = 4,
    parameter int TagW  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    input  logic [Width-1:0]        In_A,
    input  logic [Width-1:0]        In_B,
    input  logic [1:0]              In_Sel,
    output logic [Width-1:0]        Alu_A,
    output logic [Width-1:0]        Alu_B,
    output logic [1:0]              Alu_Sel,
    input  logic [2*Width-1:0]      Alu_Out,
    output logic                    Res_Valid,
    input  logic                    Res_Ready,
    output logic [2*Width-1:0]      Res_Data,
    output logic [1:0]              Res_Sel,
    output logic [TagW-1:0]         Res_Tag,
    output logic [$clog2(Depth):0]  Pending
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    typedef struct packed {
        logic [Width-1:0] a;
        logic [Width-1:0] b;
        logic [1:0]       sel;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    cmd_t            mem [Depth];
    cmd_t            head;
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [CntW-1:0] count;
    logic [TagW-1:0] tag_cnt, stage_tag;
    state_t          state_q, state_d;
    logic            push, pop, have_cmd;

    assign In_Ready = (count != CntW'(Depth));
    assign Pending  = count;
    assign push     = In_Valid && In_Ready;
    assign have_cmd = (count != '0);
    assign head     = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (have_cmd) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = HOLD;
            HOLD: begin
                if (Res_Ready) begin
                    if (have_cmd) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: storage is not reset; clearing the pointers empties it and unwritten slots are never read.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= {In_A, In_B, In_Sel};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            tag_cnt   <= '0;
            stage_tag <= '0;
            Alu_A     <= '0;
            Alu_B     <= '0;
            Alu_Sel   <= '0;
            Res_Valid <= 1'b0;
            Res_Data  <= '0;
            Res_Sel   <= '0;
            Res_Tag   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(1);

            if (pop) begin
                rd_ptr    <= rd_ptr + PtrW'(1);
                Alu_A     <= head.a;
                Alu_B     <= head.b;
                Alu_Sel   <= head.sel;
                stage_tag <= tag_cnt;
                tag_cnt   <= tag_cnt + TagW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: ;
            endcase

            // The ALU operands have been stable for the whole EXEC cycle, so Alu_Out is settled here.
            if (state_q == EXEC) begin
                Res_Valid <= 1'b1;
                Res_Data  <= Alu_Out;
                Res_Sel   <= Alu_Sel;
                Res_Tag   <= stage_tag;
            end else if (state_q == HOLD && Res_Ready) begin
                Res_Valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: models the ALU, scoreboards accepted commands and
// checks results, tags, occupancy and flow control across directed scenarios.
module tb_alu_cmd_issuer;
    localparam int W    = 8;
    localparam int D    = 4;
    localparam int TW   = 4;

    typedef struct {
        logic [2*W-1:0] data;
        logic [1:0]     sel;
        logic [TW-1:0]  tag;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      in_a = '0, in_b = '0;
    logic [1:0]        in_sel = '0;
    logic [W-1:0]      alu_a, alu_b;
    logic [1:0]        alu_sel;
    logic [2*W-1:0]    alu_out;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [2*W-1:0]    res_data;
    logic [1:0]        res_sel;
    logic [TW-1:0]     res_tag;
    logic [$clog2(D):0] pending;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    logic acc_seen, hs_seen;
    logic [TW-1:0] exp_tag;
    exp_t sb[$];
    logic [2*W-1:0] obs_data[$];
    logic [TW-1:0]  obs_tag[$];
    int             hs_cyc[$];

    always #5 clk = ~clk;

    alu_cmd_issuer #(.Width(W), .Depth(D), .TagW(TW)) dut (
        .CLK(clk), .RST(rst),
        .In_Valid(in_valid), .In_Ready(in_ready),
        .In_A(in_a), .In_B(in_b), .In_Sel(in_sel),
        .Alu_A(alu_a), .Alu_B(alu_b), .Alu_Sel(alu_sel), .Alu_Out(alu_out),
        .Res_Valid(res_valid), .Res_Ready(res_ready),
        .Res_Data(res_data), .Res_Sel(res_sel), .Res_Tag(res_tag),
        .Pending(pending)
    );

    function automatic logic [2*W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [1:0] sel);
        case (sel)
            2'b00:   return (2*W)'(a) + (2*W)'(b);
            2'b01:   return (2*W)'(a & b);
            2'b10:   return (2*W)'(a) * (2*W)'(b);
            default: return (2*W)'(a) + (2*W)'(1);
        endcase
    endfunction

    // SimpleALU stand-in
    assign alu_out = alu_fn(alu_a, alu_b, alu_sel);

    task automatic chk(input string name, input longint got, input longint exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, return just after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        acc_seen = 1'b0;
        hs_seen  = 1'b0;
        if (!rst && in_valid && in_ready) begin
            sb.push_back('{alu_fn(in_a, in_b, in_sel), in_sel, exp_tag});
            exp_tag  = exp_tag + 1'b1;
            acc_seen = 1'b1;
        end
        if (!rst && res_valid && res_ready) begin
            hs_seen = 1'b1;
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_empty: unexpected result data %0d tag %0d", res_data, res_tag);
            end else begin
                e = sb.pop_front();
                if (res_data !== e.data || res_sel !== e.sel || res_tag !== e.tag) begin
                    tests_failed++;
                    $display("FAIL sb_result: got data %0d sel %0d tag %0d expected data %0d sel %0d tag %0d",
                             res_data, res_sel, res_tag, e.data, e.sel, e.tag);
                end
            end
            obs_data.push_back(res_data);
            obs_tag.push_back(res_tag);
            hs_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic flush_model();
        sb.delete();
        obs_data.delete();
        obs_tag.delete();
        hs_cyc.delete();
        exp_tag = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        res_ready = 1'b0;
        flush_model();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] sel);
        int n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_sel = sel;
        do begin
            step();
            n++;
        end while (!acc_seen && n < 200);
        if (!acc_seen) chk("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!res_valid && n < 50) begin
            step();
            n++;
        end
        chk("wait_res_valid", res_valid, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || res_valid) && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) chk("drain_timeout", 0, 1);
    endtask

    task automatic test_reset();
        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pending", pending, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
        chk("rst_res", {res_data, res_sel, res_tag}, 0);
    endtask

    task automatic test_single();
        do_reset();
        push_cmd(8'd3, 8'd17, 2'b00);
        step();
        chk("single_alu_a_t1", alu_a, 3);
        chk("single_alu_b_t1", alu_b, 17);
        chk("single_no_valid_t1", res_valid, 0);
        step();
        chk("single_valid_t2", res_valid, 1);
        chk("single_data", res_data, 20);
        chk("single_sel", res_sel, 0);
        chk("single_tag", res_tag, 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("single_valid_drop", res_valid, 0);
        chk("single_pending", pending, 0);
        chk("single_hs_count", obs_data.size(), 1);
    endtask

    task automatic test_opcodes();
        logic [2*W-1:0] exp_d [4] = '{16'd510, 16'd255, 16'd65025, 16'd256};
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(8'd255, 8'd255, 2'(i));
        drain();
        res_ready = 1'b0;
        chk("ops_count", obs_data.size(), 4);
        if (obs_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("ops_data%0d", i), obs_data[i], exp_d[i]);
                chk($sformatf("ops_tag%0d", i), obs_tag[i], i);
            end
            for (int i = 1; i < 4; i++)
                chk($sformatf("ops_spacing%0d", i), hs_cyc[i] - hs_cyc[i-1], 2);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 5; i++) push_cmd(8'(i), 8'(20 - i), 2'b00);
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_pending_full", pending, 4);
        in_valid = 1'b1;
        in_a = 8'd99;
        in_b = 8'd99;
        in_sel = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_sixth_ignored", acc_seen, 0);
            chk("bp_pending_hold", pending, 4);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        chk("bp_ready_not_comb", in_ready, 0);
        step();
        chk("bp_ready_after_pop", in_ready, 1);
        chk("bp_pending_after_pop", pending, 3);
        drain();
        res_ready = 1'b0;
        chk("bp_count", obs_data.size(), 5);
        if (obs_data.size() == 5)
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("bp_data%0d", i), obs_data[i], 20);
                chk($sformatf("bp_tag%0d", i), obs_tag[i], i);
            end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_cmd(8'd1, 8'd2, 2'b00);
        push_cmd(8'd4, 8'd5, 2'b01);
        push_cmd(8'd6, 8'd6, 2'b11);
        wait_valid();
        chk("b2b_pending_before", pending, 2);
        res_ready = 1'b1;
        in_valid = 1'b1;
        in_a = 8'd7;
        in_b = 8'd9;
        in_sel = 2'b10;
        step();
        chk("b2b_same_edge", {acc_seen, hs_seen}, 2'b11);
        in_valid = 1'b0;
        res_ready = 1'b0;
        chk("b2b_pending_after", pending, 2);
        res_ready = 1'b1;
        drain();
        res_ready = 1'b0;
        chk("b2b_count", obs_data.size(), 4);
        if (obs_data.size() == 4) begin
            chk("b2b_order0", obs_data[0], 3);
            chk("b2b_order1", obs_data[1], 4);
            chk("b2b_order2", obs_data[2], 7);
            chk("b2b_last_data", obs_data[3], 63);
            chk("b2b_last_tag", obs_tag[3], 3);
        end
    endtask

    task automatic test_tag_wrap();
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 17; i++) push_cmd(8'(i), 8'(i), 2'b00);
        drain();
        res_ready = 1'b0;
        chk("wrap_count", obs_data.size(), 17);
        if (obs_data.size() == 17) begin
            chk("wrap_tag15", obs_tag[15], 15);
            chk("wrap_tag16", obs_tag[16], 0);
            chk("wrap_data16", obs_data[16], 32);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 4; i++) push_cmd(8'(i + 1), 8'd3, 2'b00);
        wait_valid();
        chk("mrst_pending_before", pending, 3);
        rst = 1'b1;
        flush_model();
        step();
        rst = 1'b0;
        chk("mrst_res_valid", res_valid, 0);
        chk("mrst_pending", pending, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_alu", {alu_a, alu_b, alu_sel}, 0);
        push_cmd(8'd1, 8'd1, 2'b10);
        res_ready = 1'b1;
        wait_valid();
        drain();
        res_ready = 1'b0;
        chk("mrst_count", obs_data.size(), 1);
        if (obs_data.size() == 1) begin
            chk("mrst_data", obs_data[0], 1);
            chk("mrst_tag", obs_tag[0], 0);
        end
    endtask

    initial begin
        exp_tag = '0;
        test_reset();
        test_single();
        test_opcodes();
        test_backpressure();
        test_back_to_back();
        test_tag_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Upstream issue stage for SimpleALU. Buffers operand/opcode commands from a producer in a small FIFO and drives them one at a time onto the ALU's A/B/Sel inputs. It then captures the ALU's combinational Out and presents it downstream under a valid/ready handshake, tagged with a wrap-around sequence number. This decouples command producers from result consumers and gives the otherwise purely combinational ALU a registered, flow-controlled boundary.

Parameters:
Width, 8, operand width; ALU result width is 2*Width.
Depth, 4, command FIFO entries; power of two, minimum 2.
TagW, 4, width of sequence tag.

Ports:
CLK  input  1  clock, rising-edge.
RST  input  1  synchronous, active-high reset.
In_Valid  input  1  producer has a command.
In_Ready  output  1  FIFO can accept; equals !full.
In_A  input  Width  operand A.
In_B  input  Width  operand B.
In_Sel  input  2  opcode: 00 A+B, 01 A&B, 10 A*B, 11 A+1.
Alu_A  output  Width  registered operand A to ALU.
Alu_B  output  Width  registered operand B to ALU.
Alu_Sel  output  2  registered opcode to ALU.
Alu_Out  input  2*Width  ALU combinational result.
Res_Valid  output  1  result held on Res_Data.
Res_Ready  input  1  consumer accepts result.
Res_Data  output  2*Width  captured ALU result.
Res_Sel  output  2  opcode that produced Res_Data.
Res_Tag  output  TagW  sequence number of the result.
Pending  output  clog2(Depth)+1  FIFO occupancy.

Behaviour:
- Reset (RST high at edge): all of the following clear to 0 — FIFO pointers, Pending, Alu_A/B/Sel, Res_Valid/Data/Sel/Tag, the issue tag counter. FSM goes to IDLE. Reset mid-operation discards buffered commands and any held result with no output handshake. In_Ready is 1 from the first cycle after reset.
- Push: on an edge with In_Valid & In_Ready, {In_A, In_B, In_Sel} is written at the tail. A push is never accepted while full (In_Ready=0). In_Valid without In_Ready is ignored; the producer must hold the command.
- Pop: happens only on the FSM transitions marked "pop" below. Push and pop on the same edge are legal: Pending stays the same and the pointers both advance. A pop from the full state frees In_Ready on the next cycle, not combinationally.
- Pointers wrap modulo Depth. Pending is 0..Depth.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE: if Pending>0 → pop head into Alu_A/B/Sel, latch issue tag into the stage's internal tag register, increment the issue tag counter, then go to EXEC. Otherwise stay in IDLE.
  - EXEC: Alu_* held stable for one full cycle. At the edge: Res_Data←Alu_Out, Res_Sel←Alu_Sel, Res_Tag←stage tag, Res_Valid←1, go to HOLD.
  - HOLD: Res_* held stable while Res_Ready=0.
    - Res_Ready=1 and Pending>0 → pop, load Alu_*, Res_Valid←0, go to EXEC (back-to-back).
    - Res_Ready=1 and Pending=0 → Res_Valid←0, go to IDLE.
- Alu_* keep their last value when not being loaded. They never change during EXEC.
- Latency: a command accepted at edge t0, into an empty FIFO with the FSM in IDLE, is on Alu_* after t1 and has Res_Valid=1 after t2. Sustained throughput is one result per 2 cycles with Res_Ready tied high.
- Ordering: results emerge in acceptance order. The issue tag counter wraps from 2^TagW-1 to 0.
- Res_Data is taken verbatim from Alu_Out; the stage does no arithmetic on it. Expected values are: Sel 00 → A+B zero-extended; 01 → A&B; 10 → full 2*Width product; 11 → A+1 with no truncation at Width.
- Pending counts FIFO entries only. It excludes the command currently in EXEC or HOLD.

Test Plan:
- Reset then single command: push A=3, B=17, Sel=00 → Alu_A=3 after t1; Res_Valid=1 after t2 with Res_Data=20, Res_Sel=00, Res_Tag=0; Res_Ready pulse → Res_Valid=0, FSM returns to IDLE.
- Four opcodes with A=255, B=255, pushed back-to-back and Res_Ready held high → results 510, 255, 65025, 256 in order, tags 0..3, one result every 2 cycles.
- Backpressure: Res_Ready=0, push 5 commands (A=i, B=20-i, Sel=00) → after 5 accepts In_Ready=0 and Pending=4; the 6th In_Valid is ignored. Release Res_Ready → five results, all equal to 20, tags 0..4, and In_Ready returns to 1 the cycle after the first pop.
- Simultaneous push/pop: Pending=2, push on the same edge as a HOLD→EXEC pop → Pending stays 2 and the new command emerges last.
- Tag wrap: issue 17 commands → the 17th Res_Tag=0.
- Mid-operation reset: RST asserted while in HOLD with Pending=3 → next cycle Res_Valid=0, Pending=0, In_Ready=1, Alu_*=0. A subsequent push A=1, B=1, Sel=10 yields Res_Data=1 with Res_Tag=0.
